filter_pad_source: RTL and testbench
====================================

// Module: filter_pad_source
// PURPOSE
//  Transmit side of the filter pixel stream. Converts an unpadded raster frame from upstream
//  (valid/ready) into the zero-bordered stream the convolution filter consumes: PAD rows of
//  border before/after the frame, PAD border pixels before/after every row, one strobe per pixel.
//  Sits between the frame reader and the filter; the filter has no backpressure, so bubbles
//  occur only while waiting on upstream.
// PARAMETERS
//  width        320  interior pixels per row
//  height       240  interior rows per frame
//  kernel_size  3    odd filter kernel size; PAD = (kernel_size-1)/2 (0 when kernel_size=1)
//  pad_value    0    24-bit value driven on every border pixel
// PORTS
//  clk     in   1   clock
//  reset   in   1   asynchronous, active-low reset
//  iStart  in   1   start-of-frame request, honoured only in IDLE
//  iValid  in   1   upstream pixel valid
//  iReady  out  1   block accepts iData this cycle (iValid && iReady = transfer)
//  iData   in   24  upstream pixel {R,G,B}
//  oValid  out  1   oData is a stream pixel this cycle
//  oData   out  24  padded-stream pixel {R,G,B}
//  oSof    out  1   with oValid: first pixel of frame (top-left border)
//  oEol    out  1   with oValid: last pixel of a padded row
//  oDone   out  1   with oValid: last pixel of frame
//  oBusy   out  1   frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, counters 0; oValid, oSof, oEol, oDone, oBusy, iReady = 0;
//    oData = 0. Frame in flight is abandoned; no partial completion.
//  - Row length RW = width+2*PAD; frame rows RH = height+2*PAD; one frame = RW*RH oValid pulses.
//  - Counters: col 0..RW-1, row 0..RH-1; col wraps to 0 at RW-1 and row increments; both wrap to 0
//    at frame end.
//  - FSM: IDLE -> (iStart) -> TOP -> LPAD -> DATA -> RPAD -> LPAD ... -> BOT -> IDLE.
//    TOP: row < PAD, emit border every cycle. LPAD: col < PAD. DATA: PAD <= col < PAD+width.
//    RPAD: col >= PAD+width. BOT: row >= PAD+height. Skip empty states (PAD=0: IDLE->DATA).
//  - Border pixels: oValid=1 every cycle, oData=pad_value, no upstream dependency.
//  - DATA: iReady=1 (combinational from state only, never from iValid). On transfer, next cycle
//    oValid=1, oData=iData, col advances. No transfer -> oValid=0 next cycle, counters hold.
//    iReady=0 in all other states; upstream data held there is not consumed.
//  - Outputs registered: pixel for counter position (row,col) appears 1 cycle after that position
//    is processed; first oValid (oSof) is the cycle after iStart is sampled in IDLE.
//  - oSof=1 only at (0,0); oEol=1 at col=RW-1; oDone=1 at (RH-1,RW-1); all are qualified by oValid.
//  - After the oDone pixel, FSM is in IDLE; iStart may be sampled the cycle oDone is visible,
//    giving back-to-back frames with no gap.
//  - iStart while busy: ignored, no effect on counters or outputs.
//  - Widths: counters 13 bits (RW, RH <= 8191); comparisons unsigned.
// TESTING
//  1. Hold reset=0 with iStart=iValid=1 -> all outputs 0, iReady=0; release -> IDLE, still idle.
//  2. width=4,height=3,kernel=3, iValid=1, iData=16*r+c+1: iStart -> 30 consecutive oValid;
//     pixels 0-5 and 24-29 = 0; row1 = 0,1,2,3,4,0; oSof at pixel 0; oEol at 5,11,..,29; oDone at 29.
//  3. Same frame, drop iValid for 3 cycles mid-row1 -> exactly 3 oValid=0 cycles, no extra border,
//     30 pixels total, same data.
//  4. Pulse iStart at pixels 10 and 29 of frame 1 -> first ignored; second starts frame 2 with oSof
//     directly after oDone (no gap cycle).
//  5. Assert reset at pixel 14 -> outputs 0 same cycle; release, iStart -> fresh frame of 30 with
//     oSof on pixel 0.
//  6. kernel_size=1, width=4, height=3 -> 12 pixels, no border, iReady=1 every cycle of frame,
//     oSof on 1st, oDone on 12th.

Source files
------------

// File: rtl/filter_pad_source_if.sv
// rtl/filter_pad_source_if.sv - pixel stream bundle for filter_pad_source
// Upstream side : iValid, iData (to block), iReady (from block)
// Downstream side: oValid, oData, oSof, oEol, oDone (from block)
// master = the pad source itself, slave = the surrounding environment.
interface filter_pad_source_if;
  logic        iValid;
  logic        iReady;
  logic [23:0] iData;
  logic        oValid;
  logic [23:0] oData;
  logic        oSof;
  logic        oEol;
  logic        oDone;

  modport master (
    input  iValid, iData,
    output iReady, oValid, oData, oSof, oEol, oDone
  );

  modport slave (
    output iValid, iData,
    input  iReady, oValid, oData, oSof, oEol, oDone
  );
endinterface

// File: rtl/filter_pad_source.sv
// rtl/filter_pad_source.sv - wraps an unpadded raster frame in a PAD-wide border of pad_value
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   iStart : start-of-frame request, honoured only while idle
//   oBusy  : frame in progress
//   bus    : master side of filter_pad_source_if (upstream iValid/iReady/iData,
//            downstream oValid/oData/oSof/oEol/oDone, all outputs registered)
module filter_pad_source #(
  parameter int          width       = 320,
  parameter int          height      = 240,
  parameter int          kernel_size = 3,
  parameter logic [23:0] pad_value   = 24'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iStart,
  output logic                  oBusy,
  filter_pad_source_if.master   bus
);

  localparam int         PAD      = (kernel_size - 1) / 2;
  localparam logic [12:0] PAD_W    = 13'(PAD);
  localparam logic [12:0] RPAD_COL = 13'(PAD + width);
  localparam logic [12:0] BOT_ROW  = 13'(PAD + height);
  localparam logic [12:0] COL_LAST = 13'(width + 2 * PAD - 1);
  localparam logic [12:0] ROW_LAST = 13'(height + 2 * PAD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_LPAD,
    S_DATA,
    S_RPAD,
    S_BOT
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] row_q, row_d;
  logic [12:0] col_q, col_d;
  logic        oValid_q, oValid_d;
  logic [23:0] oData_q, oData_d;
  logic        oSof_q, oSof_d;
  logic        oEol_q, oEol_d;
  logic        oDone_q, oDone_d;

  // Region of the padded frame that position (r,c) belongs to.
  // "x < PAD" is written as "x + 1 <= PAD" so that PAD = 0 does not
  // produce a comparison that is constant by construction.
  function automatic state_e classify(input logic [12:0] r, input logic [12:0] c);
    logic [13:0] r1;
    logic [13:0] c1;
    r1 = {1'b0, r} + 14'd1;
    c1 = {1'b0, c} + 14'd1;
    if (r1 <= {1'b0, PAD_W})  return S_TOP;
    if (r >= BOT_ROW)         return S_BOT;
    if (c1 <= {1'b0, PAD_W})  return S_LPAD;
    if (c < RPAD_COL)         return S_DATA;
    return S_RPAD;
  endfunction

  state_e pos_state;
  logic   active;
  logic   emit;
  logic   last_col;
  logic   last_pix;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    oValid_d = 1'b0;
    oData_d  = 24'd0;
    oSof_d   = 1'b0;
    oEol_d   = 1'b0;
    oDone_d  = 1'b0;

    // While idle the counters already sit at (0,0), so an accepted iStart
    // processes that position in the same cycle; this gives the oSof pixel
    // one cycle after iStart and back-to-back frames after oDone.
    pos_state = (state_q == S_IDLE) ? classify(row_q, col_q) : state_q;
    active    = (state_q != S_IDLE) || iStart;
    emit      = active &&
                ((pos_state != S_DATA) || ((state_q == S_DATA) && bus.iValid));
    last_col  = (col_q == COL_LAST);
    last_pix  = last_col && (row_q == ROW_LAST);

    // Borderless frame: iReady comes from state only, so the first pixel
    // has to wait for the DATA state before it can be taken.
    if ((state_q == S_IDLE) && iStart && (pos_state == S_DATA)) begin
      state_d = S_DATA;
    end

    if (emit) begin
      oValid_d = 1'b1;
      oData_d  = (pos_state == S_DATA) ? bus.iData : pad_value;
      oSof_d   = (row_q == 13'd0) && (col_q == 13'd0);
      oEol_d   = last_col;
      oDone_d  = last_pix;
      if (last_pix) begin
        row_d   = 13'd0;
        col_d   = 13'd0;
        state_d = S_IDLE;
      end else begin
        if (last_col) begin
          col_d = 13'd0;
          row_d = row_q + 13'd1;
        end else begin
          col_d = col_q + 13'd1;
        end
        state_d = classify(row_d, col_d);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      row_q    <= 13'd0;
      col_q    <= 13'd0;
      oValid_q <= 1'b0;
      oData_q  <= 24'd0;
      oSof_q   <= 1'b0;
      oEol_q   <= 1'b0;
      oDone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      oValid_q <= oValid_d;
      oData_q  <= oData_d;
      oSof_q   <= oSof_d;
      oEol_q   <= oEol_d;
      oDone_q  <= oDone_d;
    end
  end

  assign bus.iReady = (state_q == S_DATA);
  assign bus.oValid = oValid_q;
  assign bus.oData  = oData_q;
  assign bus.oSof   = oSof_q;
  assign bus.oEol   = oEol_q;
  assign bus.oDone  = oDone_q;
  assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_filter_pad_source.sv
// tb/tb_filter_pad_source.sv - scoreboard bench for filter_pad_source (kernel 3 and kernel 1 instances)
module tb_filter_pad_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start3, start1;
  logic busy3, busy1;

  filter_pad_source_if b3 ();
  filter_pad_source_if b1 ();

  filter_pad_source #(.width(4), .height(3), .kernel_size(3), .pad_value(24'h0)) u3 (
    .clk(clk), .reset(reset), .iStart(start3), .oBusy(busy3), .bus(b3.master)
  );

  filter_pad_source #(.width(4), .height(3), .kernel_size(1), .pad_value(24'h0)) u1 (
    .clk(clk), .reset(reset), .iStart(start1), .oBusy(busy1), .bus(b1.master)
  );

  int checks = 0;
  int errors = 0;

  logic [26:0] q3[$];
  logic [26:0] q1[$];
  logic [26:0] got3, exp3, got1, exp1;
  int   pix3 = 0;
  int   gap3 = 0;
  logic inf3 = 1'b0;
  int   k3 = 0;
  int   k1 = 0;
  int   drop3 = 0;
  logic x3, x1;

  function automatic logic [23:0] model(input int k);
    int r, c;
    r = k / 4;
    c = k % 4;
    return 24'(16 * r + c + 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expected padded frame for width=4, height=3, PAD=1: 6x5 pixels.
  task automatic push3();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        logic [23:0] d;
        d = 24'd0;
        if (r >= 1 && r <= 3 && c >= 1 && c <= 4) d = 24'(16 * (r - 1) + (c - 1) + 1);
        q3.push_back({(r == 0 && c == 0), (c == 5), (r == 4 && c == 5), d});
      end
    end
  endtask

  task automatic push1();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        q1.push_back({(r == 0 && c == 0), (c == 3), (r == 2 && c == 3), 24'(16 * r + c + 1)});
      end
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    #2;
    if (which == 3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    #2;
    start3 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_empty(input int which, input int budget, input string nm);
    int n;
    n = 0;
    while (((which == 3) ? q3.size() : q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    #2;
    chk(nm, 64'((which == 3) ? q3.size() : q1.size()), 64'd0);
  endtask

  task automatic wait_pix3(input int p, input int budget, input string nm);
    int n;
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      #2;
      n++;
      if (b3.oValid && pix3 == p) hit = 1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for pixel %0d", nm, p);
    end
  endtask

  // Upstream models: pixel k of the interior raster is 16*row+col+1.
  initial begin
    b3.iValid = 1'b1;
    b3.iData  = 24'd0;
    forever begin
      @(negedge clk);
      if (drop3 > 0 && (k3 % 12) == 2) begin
        b3.iValid = 1'b0;
        drop3--;
      end else begin
        b3.iValid = 1'b1;
      end
      b3.iData = model(k3 % 12);
      #1;
      x3 = b3.iValid && b3.iReady;
      @(posedge clk);
      if (x3) k3++;
    end
  end

  initial begin
    b1.iValid = 1'b1;
    b1.iData  = 24'd0;
    forever begin
      @(negedge clk);
      b1.iData = model(k1 % 12);
      #1;
      x1 = b1.iValid && b1.iReady;
      @(posedge clk);
      if (x1) k1++;
    end
  end

  // Monitors: pop expected pixel on every oValid.
  always @(negedge clk) begin
    if (!reset) begin
      inf3 = 1'b0;
    end else if (b3.oValid) begin
      got3 = {b3.oSof, b3.oEol, b3.oDone, b3.oData};
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL k3_extra_pixel got %h expected none", got3);
      end else begin
        exp3 = q3.pop_front();
        if (got3 !== exp3) begin
          errors++;
          $display("FAIL k3_pixel got %h expected %h", got3, exp3);
        end
      end
      pix3 = b3.oSof ? 0 : pix3 + 1;
      if (b3.oSof) inf3 = 1'b1;
      if (b3.oDone) inf3 = 1'b0;
    end else if (inf3) begin
      gap3++;
    end
  end

  always @(negedge clk) begin
    if (reset && b1.oValid) begin
      got1 = {b1.oSof, b1.oEol, b1.oDone, b1.oData};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL k1_extra_pixel got %h expected none", got1);
      end else begin
        exp1 = q1.pop_front();
        if (got1 !== exp1) begin
          errors++;
          $display("FAIL k1_pixel got %h expected %h", got1, exp1);
        end
      end
    end
    if (reset && busy1) begin
      checks++;
      if (b1.iReady !== 1'b1) begin
        errors++;
        $display("FAIL k1_ready got %b expected 1", b1.iReady);
      end
    end
  end

  initial begin
    reset  = 1'b0;
    start3 = 1'b1;
    start1 = 1'b1;

    // 1: reset held with iStart/iValid high
    repeat (3) @(negedge clk);
    #1;
    chk("rst_k3", 64'({b3.oValid, b3.oSof, b3.oEol, b3.oDone, busy3, b3.iReady, b3.oData}), 64'd0);
    chk("rst_k1", 64'({b1.oValid, b1.oSof, b1.oEol, b1.oDone, busy1, b1.iReady, b1.oData}), 64'd0);
    start3 = 1'b0;
    start1 = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_after_rst", 64'({busy3, b3.oValid, b3.iReady, busy1, b1.oValid}), 64'd0);

    // 2: one padded frame, first pixel the cycle after iStart
    k3 = 0;
    gap3 = 0;
    push3();
    @(negedge clk);
    #2 start3 = 1'b1;
    @(negedge clk);
    #1;
    chk("t2_first_latency", 64'({b3.oValid, b3.oSof}), 64'b11);
    #1 start3 = 1'b0;
    wait_empty(3, 100, "t2_drain");
    chk("t2_gaps", 64'(gap3), 64'd0);

    // 3: three-cycle upstream stall in row 1
    k3 = 0;
    gap3 = 0;
    drop3 = 3;
    push3();
    pulse(3);
    wait_empty(3, 100, "t3_drain");
    chk("t3_gaps", 64'(gap3), 64'd3);
    chk("t3_drop_used", 64'(drop3), 64'd0);

    // 4: iStart while busy ignored, iStart on oDone gives back-to-back frame
    k3 = 0;
    gap3 = 0;
    push3();
    push3();
    pulse(3);
    wait_pix3(10, 100, "t4_pix10");
    start3 = 1'b1;
    @(negedge clk);
    #2 start3 = 1'b0;
    wait_pix3(29, 100, "t4_pix29");
    start3 = 1'b1;
    @(negedge clk);
    #1;
    chk("t4_back_to_back", 64'({b3.oValid, b3.oSof}), 64'b11);
    #1 start3 = 1'b0;
    wait_empty(3, 100, "t4_drain");
    chk("t4_gaps", 64'(gap3), 64'd0);

    // 5: reset mid-frame, then a fresh frame
    k3 = 0;
    push3();
    pulse(3);
    wait_pix3(14, 100, "t5_pix14");
    reset = 1'b0;
    #1;
    chk("t5_async_clear", 64'({b3.oValid, b3.oSof, b3.oEol, b3.oDone, busy3, b3.iReady, b3.oData}), 64'd0);
    q3.delete();
    repeat (2) @(negedge clk);
    #2;
    k3 = 0;
    reset = 1'b1;
    gap3 = 0;
    push3();
    pulse(3);
    wait_empty(3, 100, "t5_drain");
    chk("t5_gaps", 64'(gap3), 64'd0);

    // 6: kernel 1, no border
    k1 = 0;
    push1();
    pulse(1);
    wait_empty(1, 100, "t6_drain");
    chk("t6_idle", 64'(busy1), 64'd0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
